// File: rtl/accel_ctrl_pkg.sv
// Shared types for the systolic-array job controller: FSM states, register offsets, bit indices.
// Pure declarations; no timing or flow control of its own.
package accel_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_K_LEN  = 3'd2;
    localparam logic [2:0] REG_W_BASE = 3'd3;
    localparam logic [2:0] REG_A_BASE = 3'd4;
    localparam logic [2:0] REG_R_BASE = 3'd5;
    localparam logic [2:0] REG_CYCLES = 3'd6;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/accel_csr.sv
// Wishbone slave register file for the job controller; exports config and start/abort pulses.
// Ack registered one cycle after stb&cyc, held one cycle; no wait states beyond that.
module accel_csr
    import accel_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              busy,
    input  logic              done_set,
    input  logic [CNT_W-1:0]  cycles,
    output logic [CNT_W-1:0]  k_len,
    output logic [ADDR_W-1:0] w_base,
    output logic [ADDR_W-1:0] a_base,
    output logic [ADDR_W-1:0] r_base,
    output logic              start,
    output logic              abort,
    output logic              irq
);

    logic [2:0]  idx;
    logic        access, wr, ctrl_wr, stat_wr, cfg_wr, start_req, err_set;
    logic        irq_en, done, err;
    logic [31:0] rdata;
    logic        unused_adr;

    assign idx        = wbs_adr_i[4:2];
    assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

    // A new access is only recognised while ack is low, so each request acks exactly once.
    assign access  = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr      = access & wbs_we_i;
    assign ctrl_wr = wr && (idx == REG_CTRL) && wbs_sel_i[0];
    assign stat_wr = wr && (idx == REG_STATUS) && wbs_sel_i[0];
    assign cfg_wr  = wr & ~busy;

    assign abort     = ctrl_wr & wbs_dat_i[CTRL_ABORT];
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_ABORT] & ~busy;
    assign start     = start_req && (k_len != '0);
    assign err_set   = start_req && (k_len == '0);
    assign irq       = done & irq_en;

    always_comb begin
        rdata = '0;
        case (idx)
            REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done;
                rdata[STAT_ERR]  = err;
            end
            REG_K_LEN:  rdata = 32'(k_len);
            REG_W_BASE: rdata = 32'(w_base);
            REG_A_BASE: rdata = 32'(a_base);
            REG_R_BASE: rdata = 32'(r_base);
            REG_CYCLES: rdata = 32'(cycles);
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            k_len     <= '0;
            w_base    <= '0;
            a_base    <= '0;
            r_base    <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= (access & ~wbs_we_i) ? rdata : '0;
            if (ctrl_wr) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            // Hardware set beats a same-cycle software clear.
            if (done_set)                           done <= 1'b1;
            else if (stat_wr && wbs_dat_i[STAT_DONE]) done <= 1'b0;
            if (err_set)                            err <= 1'b1;
            else if (stat_wr && wbs_dat_i[STAT_ERR])  err <= 1'b0;
            if (cfg_wr) begin
                case (idx)
                    REG_K_LEN:  k_len  <= CNT_W'(byte_merge(32'(k_len), wbs_dat_i, wbs_sel_i));
                    REG_W_BASE: w_base <= ADDR_W'(byte_merge(32'(w_base), wbs_dat_i, wbs_sel_i));
                    REG_A_BASE: a_base <= ADDR_W'(byte_merge(32'(a_base), wbs_dat_i, wbs_sel_i));
                    REG_R_BASE: r_base <= ADDR_W'(byte_merge(32'(r_base), wbs_dat_i, wbs_sel_i));
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/accel_job_controller.sv
// Job sequencer for the systolic array: weight load, feed, flush, drain, done; strobes are
// decoded combinationally from state and beat count. No backpressure from the array or SRAMs.
module accel_job_controller
    import accel_ctrl_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 4,
    parameter int ADDR_W  = 16,
    parameter int CNT_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              w_rd_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic              a_rd_o,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic              arr_en_o,
    output logic              arr_clr_o,
    output logic              r_wr_o,
    output logic [ADDR_W-1:0] r_addr_o,
    output logic              busy_o,
    output logic              irq_o
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat, cycles, k_len;
    logic [ADDR_W-1:0] w_base, a_base, r_base, beat_a;
    logic              start, abort, done_set;

    accel_csr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_csr (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .busy      (busy_o),
        .done_set  (done_set),
        .cycles    (cycles),
        .k_len     (k_len),
        .w_base    (w_base),
        .a_base    (a_base),
        .r_base    (r_base),
        .start     (start),
        .abort     (abort),
        .irq       (irq_o)
    );

    assign busy_o   = (state != ST_IDLE);
    assign done_set = (state == ST_DONE) && !abort;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
            ST_LOAD_W: if (beat == CNT_W'(ROWS - 1)) state_nxt = ST_FEED;
            ST_FEED:   if (beat == k_len - CNT_W'(1)) state_nxt = ST_FLUSH;
            ST_FLUSH:  if (beat == CNT_W'(ROWS + COLUMNS - 2)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (beat == CNT_W'(ROWS - 1)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    // beat restarts at every phase boundary; cycles counts busy time of the current job.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            beat   <= '0;
            cycles <= '0;
        end else begin
            beat <= (state_nxt != state || state == ST_IDLE) ? '0 : beat + CNT_W'(1);
            if (start)                        cycles <= '0;
            else if (busy_o && cycles != '1)  cycles <= cycles + CNT_W'(1);
        end
    end

    assign beat_a    = ADDR_W'(beat);
    assign w_rd_o    = (state == ST_LOAD_W);
    assign a_rd_o    = (state == ST_FEED);
    assign r_wr_o    = (state == ST_DRAIN);
    assign arr_en_o  = a_rd_o | (state == ST_FLUSH);
    assign arr_clr_o = a_rd_o && (beat == '0);
    assign w_addr_o  = w_rd_o ? w_base + beat_a : '0;
    assign a_addr_o  = a_rd_o ? a_base + beat_a : '0;
    assign r_addr_o  = r_wr_o ? r_base + beat_a : '0;

endmodule

// File: tb/tb_accel_job_controller.sv
// Directed self-checking bench for accel_job_controller.
module tb_accel_job_controller;

    localparam logic [2:0] I_CTRL = 3'd0, I_STATUS = 3'd1, I_K_LEN = 3'd2, I_W_BASE = 3'd3;
    localparam logic [2:0] I_A_BASE = 3'd4, I_R_BASE = 3'd5, I_CYCLES = 3'd6;

    logic        clk, rst, stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        w_rd, a_rd, arr_en, arr_clr, r_wr, busy, irq;
    logic [15:0] w_addr, a_addr, r_addr;

    int checks = 0;
    int failures = 0;

    accel_job_controller dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .w_rd_o    (w_rd),
        .w_addr_o  (w_addr),
        .a_rd_o    (a_rd),
        .a_addr_o  (a_addr),
        .arr_en_o  (arr_en),
        .arr_clr_o (arr_clr),
        .r_wr_o    (r_wr),
        .r_addr_o  (r_addr),
        .busy_o    (busy),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = s;
        adr = {27'd0, idx, 2'b00}; dat_w = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 8);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack idx=%0d got=%b want=1", idx, ack);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF;
        adr = {27'd0, idx, 2'b00};
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 8);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL rd_ack idx=%0d got=%b want=1", idx, ack);
        end
        d = dat_r;
        stb = 1'b0; cyc = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [54:0] obs;
        rst = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
        #23;
        obs = {ack, busy, irq, w_rd, w_addr, a_rd, a_addr, arr_en, arr_clr, r_wr, r_addr};
        checks++;
        if (obs !== 55'd0 || dat_r !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h want=0/0", obs, dat_r);
        end
        rst = 1'b1;
        step(2);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF; adr = {27'd0, I_K_LEN, 2'b00};
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL ack_latency got=%b want=1", ack);
        end
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_one_cycle got=%b want=0", ack);
        end
        for (int i = 0; i < 8; i++) begin
            wb_read(3'(i), rd);
            checks++;
            if (rd !== 32'd0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h want=0", i, rd);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
    endtask

    task automatic test_job();
        logic [31:0] rd;
        logic [53:0] obs, exp_v;
        logic        e_wrd, e_ard, e_en, e_clr, e_rwr;
        logic [15:0] e_wa, e_aa, e_ra;
        wb_write(I_K_LEN, 32'd3, 4'hF);
        wb_write(I_W_BASE, 32'h10, 4'hF);
        wb_write(I_A_BASE, 32'h20, 4'hF);
        wb_write(I_R_BASE, 32'h30, 4'hF);
        wb_write(I_CTRL, 32'h5, 4'hF);
        for (int c = 0; c < 19; c++) begin
            e_wrd = 0; e_ard = 0; e_en = 0; e_clr = 0; e_rwr = 0;
            e_wa = '0; e_aa = '0; e_ra = '0;
            if (c < 4) begin
                e_wrd = 1; e_wa = 16'(16'h10 + c);
            end else if (c < 7) begin
                e_ard = 1; e_en = 1; e_aa = 16'(16'h20 + c - 4); e_clr = (c == 4);
            end else if (c < 14) begin
                e_en = 1;
            end else if (c < 18) begin
                e_rwr = 1; e_ra = 16'(16'h30 + c - 14);
            end
            exp_v = {1'b1, e_wrd, e_wa, e_ard, e_aa, e_en, e_clr, e_rwr, e_ra};
            obs = {busy, w_rd, w_addr, a_rd, a_addr, arr_en, arr_clr, r_wr, r_addr};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL job_cycle%0d got=%h want=%h", c, obs, exp_v);
            end
            step(1);
        end
        checks++;
        if (busy !== 1'b0 || irq !== 1'b1) begin
            failures++;
            $display("FAIL job_end busy/irq got=%b%b want=01", busy, irq);
        end
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL job_status got=%h want=2", rd);
        end
        wb_read(I_CYCLES, rd);
        checks++;
        if (rd !== 32'd19) begin
            failures++;
            $display("FAIL job_cycles got=%0d want=19", rd);
        end
        wb_write(I_STATUS, 32'h2, 4'hF);
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL done_w1c got=%h irq=%b want=0 irq=0", rd, irq);
        end
    endtask

    task automatic test_zero_len();
        logic [31:0] rd;
        wb_write(I_K_LEN, 32'd0, 4'hF);
        wb_write(I_CTRL, 32'h1, 4'hF);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_busy got=%b want=0", busy);
        end
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++;
            $display("FAIL zero_len_err got=%h want=4", rd);
        end
        wb_write(I_STATUS, 32'h4, 4'hF);
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL err_w1c got=%h want=0", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic [52:0] obs;
        wb_write(I_K_LEN, 32'd3, 4'hF);
        wb_write(I_CTRL, 32'h5, 4'hF);
        step(4);
        checks++;
        if (a_rd !== 1'b1 || arr_clr !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_feed a_rd/clr got=%b%b want=11", a_rd, arr_clr);
        end
        wb_write(I_CTRL, 32'h6, 4'hF);
        obs = {busy, w_rd, w_addr, a_rd, a_addr, arr_en, arr_clr, r_wr, r_addr};
        checks++;
        if (obs !== 53'd0) begin
            failures++;
            $display("FAIL abort_idle got=%h want=0", obs);
        end
        step(20);
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL abort_done got=%h irq=%b want=0 irq=0", rd, irq);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] rd;
        int n;
        wb_write(I_K_LEN, 32'd3, 4'hF);
        wb_write(I_W_BASE, 32'h1234, 4'hF);
        wb_write(I_CTRL, 32'h1, 4'hF);
        wb_write(I_K_LEN, 32'd7, 4'hF);
        wb_write(I_CTRL, 32'h1, 4'hF);
        n = 0;
        while (busy && n < 40) begin
            step(1); n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_timeout got=%b want=0", busy);
        end
        wb_read(I_K_LEN, rd);
        checks++;
        if (rd !== 32'd3) begin
            failures++;
            $display("FAIL klen_locked got=%0d want=3", rd);
        end
        wb_read(I_CYCLES, rd);
        checks++;
        if (rd !== 32'd19) begin
            failures++;
            $display("FAIL restart_ignored cycles got=%0d want=19", rd);
        end
        wb_write(I_STATUS, 32'h2, 4'hF);
        wb_write(I_W_BASE, 32'h0000ABCD, 4'b0001);
        wb_read(I_W_BASE, rd);
        checks++;
        if (rd !== 32'h12CD) begin
            failures++;
            $display("FAIL byte_sel got=%h want=12cd", rd);
        end
    endtask

    task automatic test_wrap_and_w1c_race();
        logic [31:0] rd;
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        wb_write(I_W_BASE, 32'hFFFE, 4'hF);
        wb_write(I_K_LEN, 32'd1, 4'hF);
        wb_write(I_CTRL, 32'h1, 4'hF);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (w_rd !== 1'b1 || w_addr !== exp_a[c]) begin
                failures++;
                $display("FAIL wrap%0d got=%b/%h want=1/%h", c, w_rd, w_addr, exp_a[c]);
            end
            step(1);
        end
        step(12);
        checks++;
        if (busy !== 1'b1 || r_wr !== 1'b0 || arr_en !== 1'b0) begin
            failures++;
            $display("FAIL done_state busy/r_wr/en got=%b%b%b want=100", busy, r_wr, arr_en);
        end
        wb_write(I_STATUS, 32'h2, 4'hF);
        wb_read(I_STATUS, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL set_beats_w1c got=%h want=2", rd);
        end
        wb_write(I_STATUS, 32'h2, 4'hF);
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        logic [53:0] obs;
        wb_write(I_K_LEN, 32'd3, 4'hF);
        wb_write(I_CTRL, 32'h5, 4'hF);
        step(5);
        #2;
        rst = 1'b0;
        #1;
        obs = {busy, irq, w_rd, w_addr, a_rd, a_addr, arr_en, arr_clr, r_wr, r_addr};
        checks++;
        if (obs !== 54'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        #3;
        rst = 1'b1;
        wb_read(I_K_LEN, rd);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL async_reset_klen got=%0d want=0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_job();
        test_zero_len();
        test_abort();
        test_busy_writes();
        test_wrap_and_w1c_race();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
